approx_err_stats: RTL and testbench

- Streaming error-statistics collector; sits directly downstream of the approximate lower-part-OR adder.
- Per sample it consumes the operand pair and the adder's approximate sum. It recomputes the exact sum internally and forms the absolute error distance.
- Over a programmable window it accumulates total error, maximum error and sample count, then presents the results to a consumer through a valid/ready handshake.
- Used for on-chip characterisation of approximate adders without a software reference model.

---
 rtl/approx_pkg.sv | 21 ++
 rtl/approx_err_dist.sv | 25 ++
 rtl/approx_err_stats.sv | 161 ++++++++++++++++
 tb/tb_approx_err_stats.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// Shared types, default sizes and helpers for the approximate-adder error monitor.
package approx_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefAccWidth = 32;
  localparam int unsigned DefCntWidth = 16;

  // Unsigned add clamped to the all-ones value of a width-bit accumulator (width <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0]   acc,
                                          input logic [63:0]   inc,
                                          input int unsigned   width);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (sum[64] || (sum[63:0] > lim)) ? lim : sum[63:0];
  endfunction

endpackage

// File: rtl/approx_err_dist.sv
// Combinational error distance: |(a + b) mod 2^WIDTH - approx|.
module approx_err_dist
  import approx_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] approx_i,
  output logic [WIDTH-1:0] err_o
);

  logic [WIDTH-1:0] exact;

  always_comb begin
    // Carry-out dropped so the reference truncates exactly like the adder output.
    exact = a_i + b_i;
    if (exact >= approx_i) begin
      err_o = exact - approx_i;
    end else begin
      err_o = approx_i - exact;
    end
  end

endmodule

// File: rtl/approx_err_stats.sv
// Windowed error statistics for an approximate adder: total, max and count of |exact - approx|.
// Define APPROX_ERR_RATE_EN to add res_nz_count_o (number of samples with non-zero error).
module approx_err_stats
  import approx_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned CNT_WIDTH = DefCntWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] cfg_len_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_a_i,
  input  logic [WIDTH-1:0]     in_b_i,
  input  logic [WIDTH-1:0]     in_approx_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [ACC_WIDTH-1:0] res_total_o,
  output logic [WIDTH-1:0]     res_max_o,
  output logic [CNT_WIDTH-1:0] res_count_o,
`ifdef APPROX_ERR_RATE_EN
  output logic [CNT_WIDTH-1:0] res_nz_count_o,
`endif
  output logic                 busy_o
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic                 s1_valid_q;
  logic [WIDTH-1:0]     s1_err_q;
  logic [WIDTH-1:0]     err;
  logic [ACC_WIDTH-1:0] total_q, total_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 accept;
  logic                 clear;
`ifdef APPROX_ERR_RATE_EN
  logic [CNT_WIDTH-1:0] nz_q, nz_d;
`endif

  approx_err_dist #(
    .WIDTH (WIDTH)
  ) u_dist (
    .a_i      (in_a_i),
    .b_i      (in_b_i),
    .approx_i (in_approx_i),
    .err_o    (err)
  );

  assign in_ready_o  = (state_q == StRun);
  assign res_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign accept      = in_valid_i && in_ready_o;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    acc_cnt_d = acc_cnt_q;
    clear     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d     = cfg_len_i;
          acc_cnt_d = '0;
          clear     = 1'b1;
          state_d   = (cfg_len_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
          if (acc_cnt_d == len_q) begin
            state_d = StDrain;
          end
        end
      end
      // Accumulators are the second stage, so an empty stage 1 means everything has landed.
      StDrain: begin
        if (!s1_valid_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    total_d = total_q;
    max_d   = max_q;
    count_d = count_q;
`ifdef APPROX_ERR_RATE_EN
    nz_d    = nz_q;
`endif
    if (clear) begin
      total_d = '0;
      max_d   = '0;
      count_d = '0;
`ifdef APPROX_ERR_RATE_EN
      nz_d    = '0;
`endif
    end else if (s1_valid_q) begin
      total_d = ACC_WIDTH'(sat_add(64'(total_q), 64'(s1_err_q), ACC_WIDTH));
      if (s1_err_q > max_q) begin
        max_d = s1_err_q;
      end
      count_d = count_q + CNT_WIDTH'(1);
`ifdef APPROX_ERR_RATE_EN
      if (s1_err_q != '0) begin
        nz_d = nz_q + CNT_WIDTH'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      len_q      <= '0;
      acc_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= '0;
      total_q    <= '0;
      max_q      <= '0;
      count_q    <= '0;
`ifdef APPROX_ERR_RATE_EN
      nz_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      acc_cnt_q  <= acc_cnt_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_err_q <= err;
      end
      total_q    <= total_d;
      max_q      <= max_d;
      count_q    <= count_d;
`ifdef APPROX_ERR_RATE_EN
      nz_q       <= nz_d;
`endif
    end
  end

  assign res_total_o = total_q;
  assign res_max_o   = max_q;
  assign res_count_o = count_q;
`ifdef APPROX_ERR_RATE_EN
  assign res_nz_count_o = nz_q;
`endif

endmodule

// File: tb/tb_approx_err_stats.sv
// Scoreboard bench for approx_err_stats: stimulus pushes expected result sets, monitors pop them.
module tb_approx_err_stats;

  localparam int unsigned W   = 16;
  localparam int unsigned AW  = 32;
  localparam int unsigned CW  = 16;
  localparam int unsigned SAW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, in_valid, in_ready, res_valid, res_ready, busy;
  logic [CW-1:0] cfg_len, res_count;
  logic [W-1:0]  in_a, in_b, in_approx, res_max;
  logic [AW-1:0] res_total;

  logic           s_start, s_in_valid, s_in_ready, s_res_valid, s_res_ready, s_busy;
  logic [CW-1:0]  s_cfg_len, s_res_count;
  logic [W-1:0]   s_in_a, s_in_b, s_in_approx, s_res_max;
  logic [SAW-1:0] s_res_total;
`ifdef APPROX_ERR_RATE_EN
  logic [CW-1:0] res_nz, s_res_nz;
`endif

  typedef struct packed {
    logic [AW-1:0] total;
    logic [W-1:0]  max;
    logic [CW-1:0] count;
    logic [CW-1:0] nz;
  } res_t;

  res_t exp_q[$];
  res_t sat_q[$];
  int   errors = 0;
  int   checks = 0;

  approx_err_stats #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .cfg_len_i   (cfg_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_approx_i (in_approx),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_total_o (res_total),
    .res_max_o   (res_max),
    .res_count_o (res_count),
`ifdef APPROX_ERR_RATE_EN
    .res_nz_count_o (res_nz),
`endif
    .busy_o      (busy)
  );

  approx_err_stats #(.WIDTH(W), .ACC_WIDTH(SAW), .CNT_WIDTH(CW)) dut_sat (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (s_start),
    .cfg_len_i   (s_cfg_len),
    .in_valid_i  (s_in_valid),
    .in_ready_o  (s_in_ready),
    .in_a_i      (s_in_a),
    .in_b_i      (s_in_b),
    .in_approx_i (s_in_approx),
    .res_valid_o (s_res_valid),
    .res_ready_i (s_res_ready),
    .res_total_o (s_res_total),
    .res_max_o   (s_res_max),
    .res_count_o (s_res_count),
`ifdef APPROX_ERR_RATE_EN
    .res_nz_count_o (s_res_nz),
`endif
    .busy_o      (s_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] t, input logic [W-1:0] m,
                          input logic [CW-1:0] c, input logic [CW-1:0] nz);
    res_t e;
    e.total = t; e.max = m; e.count = c; e.nz = nz;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got count %0d expected no result", res_count);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("res_total", 64'(res_total), 64'(e.total));
        check("res_max", 64'(res_max), 64'(e.max));
        check("res_count", 64'(res_count), 64'(e.count));
`ifdef APPROX_ERR_RATE_EN
        check("res_nz_count", 64'(res_nz), 64'(e.nz));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_res_valid && s_res_ready) begin
      if (sat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sat_unexpected_result: got count %0d expected no result", s_res_count);
      end else begin
        res_t e;
        e = sat_q.pop_front();
        check("sat_res_total", 64'(s_res_total), 64'(e.total));
        check("sat_res_max", 64'(s_res_max), 64'(e.max));
        check("sat_res_count", 64'(s_res_count), 64'(e.count));
`ifdef APPROX_ERR_RATE_EN
        check("sat_res_nz_count", 64'(s_res_nz), 64'(e.nz));
`endif
      end
    end
  end

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic start_win(input logic [CW-1:0] len);
    cfg_len = len;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ap, input int gap);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
    end
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_result(input string name);
    int  n    = 0;
    bit  seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        seen = 1'b1;
        n    = i;
      end
    end
    checks++;
    if (!seen || n < 2 || n > 3) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0d) expected 2..3", name, n, seen);
    end
  endtask

  task automatic finish_window(input string name);
    for (int i = 0; i < 20 && res_valid; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_released"}, 64'(res_valid), 64'(0));
  endtask

  initial begin
    start = 0; cfg_len = '0; in_valid = 0; in_a = '0; in_b = '0; in_approx = '0; res_ready = 1;
    s_start = 0; s_cfg_len = '0; s_in_valid = 0; s_in_a = '0; s_in_b = '0; s_in_approx = '0;
    s_res_ready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_total", 64'(res_total), 64'(0));
    check("rst_max", 64'(res_max), 64'(0));
    check("rst_count", 64'(res_count), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic window: errors 1, 1, 128
    push_exp(130, 128, 3, 3);
    start_win(3);
    check("run_busy", 64'(busy), 64'(1));
    send(16'h00FF, 16'h0001, 16'h00FF, 0);
    send(16'h00FF, 16'h00FF, 16'h01FF, 0);
    send(16'h0080, 16'h0080, 16'h0180, 0);
    wait_result("basic");
    finish_window("basic");

    // Reset mid-window
    start_win(5);
    send(16'h0001, 16'h0001, 16'h0010, 0);
    send(16'h0002, 16'h0002, 16'h0020, 0);
    send(16'h0003, 16'h0003, 16'h0030, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    check("midrst_res_valid", 64'(res_valid), 64'(0));
    check("midrst_total", 64'(res_total), 64'(0));
    check("midrst_max", 64'(res_max), 64'(0));
    check("midrst_count", 64'(res_count), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Gapped input, all exact
    push_exp(0, 0, 4, 0);
    start_win(4);
    send(16'h0001, 16'h0002, 16'h0003, 1);
    send(16'hFFFF, 16'h0001, 16'h0000, 1);
    send(16'h1234, 16'h4321, 16'h5555, 1);
    send(16'h8000, 16'h8000, 16'h0000, 0);
    check("gap_in_ready_after_last", 64'(in_ready), 64'(0));
    wait_result("gapped");
    finish_window("gapped");

    // Backpressure: errors 17 and 16
    res_ready = 1'b0;
    push_exp(33, 17, 2, 2);
    start_win(2);
    send(16'h1000, 16'h0001, 16'h0FF0, 0);
    send(16'h0010, 16'h0020, 16'h0040, 0);
    wait_result("bp");
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        cfg_len = '0;
        start   = 1'b1;
      end else begin
        start   = 1'b0;
      end
      check("bp_res_valid", 64'(res_valid), 64'(1));
      check("bp_total", 64'(res_total), 64'(33));
      check("bp_max", 64'(res_max), 64'(17));
      check("bp_count", 64'(res_count), 64'(2));
      @(posedge clk); #1;
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_busy", 64'(busy), 64'(0));
    check("bp_idle_res_valid", 64'(res_valid), 64'(0));
    check("bp_idle_hold_total", 64'(res_total), 64'(33));

    // Zero length goes straight to DONE with cleared results
    push_exp(0, 0, 0, 0);
    start_win(0);
    check("zero_len_done", 64'(res_valid), 64'(1));
    finish_window("zero");

    // Carry-out wrap: 0xFFFF + 0xFFFF truncates to 0xFFFE
    push_exp(0, 0, 1, 0);
    start_win(1);
    send(16'hFFFF, 16'hFFFF, 16'hFFFE, 0);
    wait_result("wrap");
    finish_window("wrap");

    // Saturation on an 8-bit accumulator: 100 + 100 + 100 clamps at 255
    begin
      res_t e;
      int   acc = 0;
      bit   seen = 1'b0;
      e.total = 255; e.max = 100; e.count = 3; e.nz = 3;
      sat_q.push_back(e);
      s_cfg_len = 3;
      s_start   = 1'b1;
      @(posedge clk); #1;
      s_start   = 1'b0;
      s_in_a = 16'd0; s_in_b = 16'd100; s_in_approx = 16'd0; s_in_valid = 1'b1;
      for (int n = 0; n < 20 && acc < 3; n++) begin
        @(negedge clk);
        if (s_in_ready) acc++;
        @(posedge clk); #1;
      end
      s_in_valid = 1'b0;
      check("sat_accepts", 64'(acc), 64'(3));
      for (int n = 0; n < 10 && !seen; n++) begin
        @(posedge clk); #1;
        if (s_res_valid) seen = 1'b1;
      end
      check("sat_res_seen", 64'(seen), 64'(1));
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("exp_queue_drained", 64'(exp_q.size()), 64'(0));
    check("sat_queue_drained", 64'(sat_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 expected earlier finish");
    $fatal(1);
  end

endmodule
